// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
package irq_pkg;

  localparam int unsigned DEF_NSRC    = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Index width for an n-source controller. Kept at 1 or more so a port is always declarable.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IRQ_ID_W = id_width(DEF_NSRC);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_REL = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit wins.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = DEF_NSRC
) (
  input  logic [NSRC-1:0]             i_req,
  output logic [id_width(NSRC)-1:0]   o_idx_c,
  output logic                        o_valid_c
);

  localparam int unsigned ID_W = id_width(NSRC);

  // Scan from the top down so the lowest index is written last.
  always_comb begin
    o_idx_c = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx_c = ID_W'(i);
    end
  end

  assign o_valid_c = |i_req;

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: latches source events, presents one
// request at a time to the processor and withdraws it if not acknowledged in time.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NSRC    = DEF_NSRC,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NSRC-1:0]             irq_src,
  input  logic                        mask_we,
  input  logic [NSRC-1:0]             mask_wdata,
  input  logic                        ExtIAck,
  output logic                        ExtIRQ,
  output logic [id_width(NSRC)-1:0]   irq_id,
  output logic [NSRC-1:0]             pending,
  output logic                        timeout
);

  localparam int unsigned ID_W  = id_width(NSRC);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  irq_state_e         r_state;
  logic [NSRC-1:0]    r_src_q;
  logic [NSRC-1:0]    r_mask;
  logic [NSRC-1:0]    r_pending;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_irq;
  logic               r_timeout;

  logic [NSRC-1:0]    w_event;
  logic [NSRC-1:0]    w_eligible;
  logic [NSRC-1:0]    w_clr;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_win_valid;
  logic               w_ack;
  logic               w_expired;

  assign w_event    = irq_src & ~r_src_q;
  assign w_eligible = r_pending & r_mask;
  assign w_ack      = (r_state == ST_ASSERT) && ExtIAck;
  assign w_expired  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Acknowledge clears the serviced bit; an event in the same cycle re-sets it below.
  always_comb begin
    w_clr = '0;
    if (w_ack) w_clr = NSRC'(1) << r_id;
  end

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .i_req     (w_eligible),
    .o_idx_c   (w_win_idx),
    .o_valid_c (w_win_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_src_q   <= irq_src;
      r_mask    <= '1;
      r_pending <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_src_q   <= irq_src;
      r_pending <= (r_pending & ~w_clr) | w_event;
      r_timeout <= 1'b0;
      if (mask_we) r_mask <= mask_wdata;

      case (r_state)
        ST_IDLE: begin
          r_irq <= 1'b0;
          r_cnt <= '0;
          if (w_win_valid) begin
            r_state <= ST_ASSERT;
            r_id    <= w_win_idx;
            r_irq   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (ExtIAck) begin
            r_state <= ST_WAIT_REL;
            r_irq   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_REL: begin
          r_irq <= 1'b0;
          if (!ExtIAck) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign ExtIRQ  = r_irq;
  assign irq_id  = r_id;
  assign pending = r_pending;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int unsigned NSRC = 4;
  localparam int unsigned TMO  = 8;

  logic                 clk;
  logic                 reset;
  logic [NSRC-1:0]      irq_src;
  logic                 mask_we;
  logic [NSRC-1:0]      mask_wdata;
  logic                 ext_iack;
  logic                 ext_irq;
  logic [IRQ_ID_W-1:0]  irq_id;
  logic [NSRC-1:0]      pending;
  logic                 tmo_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(
    .NSRC    (NSRC),
    .TIMEOUT (TMO)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ExtIAck    (ext_iack),
    .ExtIRQ     (ext_irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .timeout    (tmo_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    reset = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ext_iack = 1'b0;
    tick(); tick();
    chk_eq("rst_irq",     32'(ext_irq),   32'd0);
    chk_eq("rst_pending", 32'(pending),   32'd0);
    chk_eq("rst_id",      32'(irq_id),    32'd0);
    chk_eq("rst_timeout", 32'(tmo_pulse), 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    // Single event on source 2, ack after a few cycles.
    irq_src = 4'b0100;
    tick();
    chk_eq("s1_pend",  32'(pending), 32'h4);
    chk_eq("s1_irq_early", 32'(ext_irq), 32'd0);
    tick();
    chk_eq("s1_irq",   32'(ext_irq), 32'd1);
    chk_eq("s1_id",    32'(irq_id),  32'd2);
    irq_src = '0;
    repeat (3) tick();
    chk_eq("s1_hold",  32'(ext_irq), 32'd1);
    ext_iack = 1'b1;
    tick();
    chk_eq("s1_drop",  32'(ext_irq), 32'd0);
    chk_eq("s1_clear", 32'(pending), 32'd0);
    ext_iack = 1'b0;
    tick(); tick();
    chk_eq("s1_idle",  32'(ext_irq), 32'd0);

    // Simultaneous events on sources 1 and 3: serviced lowest first.
    irq_src = 4'b1010;
    tick();
    chk_eq("pr_pend", 32'(pending), 32'hA);
    tick();
    chk_eq("pr_irq1", 32'(ext_irq), 32'd1);
    chk_eq("pr_id1",  32'(irq_id),  32'd1);
    irq_src = '0;
    ext_iack = 1'b1;
    tick();
    chk_eq("pr_drop",  32'(ext_irq), 32'd0);
    chk_eq("pr_pend2", 32'(pending), 32'h8);
    ext_iack = 1'b0;
    tick();
    chk_eq("pr_gap",  32'(ext_irq), 32'd0);
    tick();
    chk_eq("pr_irq2", 32'(ext_irq), 32'd1);
    chk_eq("pr_id2",  32'(irq_id),  32'd3);
    ext_iack = 1'b1; tick();
    ext_iack = 1'b0; tick();
    chk_eq("pr_empty", 32'(pending), 32'd0);

    // Unacknowledged request is withdrawn after TMO cycles, then re-raised.
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    hi = 0;
    while (ext_irq && hi < 20) begin
      hi++;
      tick();
    end
    chk_eq("to_len",    32'(hi),        32'(TMO));
    chk_eq("to_pulse",  32'(tmo_pulse), 32'd1);
    chk_eq("to_keep",   32'(pending),   32'h1);
    tick();
    chk_eq("to_pulse1", 32'(tmo_pulse), 32'd0);
    chk_eq("to_reraise", 32'(ext_irq),  32'd1);
    chk_eq("to_id",     32'(irq_id),    32'd0);
    ext_iack = 1'b1; tick();
    ext_iack = 1'b0; tick();

    // Masked source latches but does not request until unmasked.
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick(); tick();
    chk_eq("mk_noirq", 32'(ext_irq), 32'd0);
    chk_eq("mk_pend",  32'(pending), 32'h1);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    chk_eq("mk_wait", 32'(ext_irq), 32'd0);
    tick();
    chk_eq("mk_irq",  32'(ext_irq), 32'd1);
    chk_eq("mk_id",   32'(irq_id),  32'd0);
    // Masking the active source leaves the request standing.
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    chk_eq("mk_stay", 32'(ext_irq), 32'd1);
    ext_iack = 1'b1; tick();
    ext_iack = 1'b0; tick();
    chk_eq("mk_empty", 32'(pending), 32'd0);

    // New edge on the serviced source during its ack cycle is kept.
    irq_src = 4'b0100;
    tick(); tick();
    chk_eq("co_irq", 32'(ext_irq), 32'd1);
    irq_src = '0;
    tick();
    irq_src = 4'b0100; ext_iack = 1'b1;
    tick();
    chk_eq("co_drop", 32'(ext_irq), 32'd0);
    chk_eq("co_pend", 32'(pending), 32'h4);
    ext_iack = 1'b0; irq_src = '0;
    tick();
    chk_eq("co_gap",  32'(ext_irq), 32'd0);
    tick();
    chk_eq("co_irq2", 32'(ext_irq), 32'd1);
    chk_eq("co_id2",  32'(irq_id),  32'd2);
    ext_iack = 1'b1; tick();
    ext_iack = 1'b0; tick();

    // Reset while a request is up, with the source line held high.
    irq_src = 4'b0010;
    tick(); tick();
    chk_eq("rm_irq", 32'(ext_irq), 32'd1);
    reset = 1'b1;
    tick();
    chk_eq("rm_drop", 32'(ext_irq), 32'd0);
    chk_eq("rm_pend", 32'(pending), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk_eq("rm_quiet",  32'(ext_irq), 32'd0);
    chk_eq("rm_pend2",  32'(pending), 32'd0);
    irq_src = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
